// File: rtl/module_calc_ctrl.sv
// Keypad calculator sequencer: assembles two BCD operands from key strobes,
// hands them to the BCD adder over valid/ready and shows the returned sum.
module module_calc_ctrl #(
    parameter int DIGITS = 3,
    parameter int W      = 4 * DIGITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    output logic [W-1:0]   first_num,
    output logic [W-1:0]   second_num,
    output logic           op_valid,
    input  logic           op_ready,
    input  logic           res_valid,
    input  logic [W+3:0]   res_data,
    output logic [W+3:0]   disp_value,
    output logic [2:0]     state
);

    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        REQUEST  = 3'd2,
        WAIT_RES = 3'd3,
        SHOW     = 3'd4
    } state_t;

    state_t          cur_state, nxt_state;
    logic [W-1:0]    first_nxt, second_nxt;
    logic [W+3:0]    result_q, result_nxt, disp_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            is_digit, is_next, is_clear, cnt_full;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_next  = key_valid && (key_code == 4'hA);
    assign is_clear = key_valid && (key_code == 4'hB);
    assign cnt_full = (cnt_q == CW'(DIGITS));
    assign state    = cur_state;

    always_comb begin
        nxt_state  = cur_state;
        first_nxt  = first_num;
        second_nxt = second_num;
        result_nxt = result_q;
        cnt_nxt    = cnt_q;
        disp_nxt   = '0;
        case (cur_state)
            ENTER_A: begin
                if (is_clear) begin
                    first_nxt  = '0;
                    second_nxt = '0;
                    result_nxt = '0;
                    cnt_nxt    = '0;
                end else if (is_next) begin
                    nxt_state  = ENTER_B;
                    second_nxt = '0;
                    cnt_nxt    = '0;
                end else if (is_digit && !cnt_full) begin
                    first_nxt = {first_num[W-5:0], key_code};
                    cnt_nxt   = cnt_q + 1'b1;
                end
            end
            ENTER_B: begin
                if (is_clear) begin
                    nxt_state  = ENTER_A;
                    first_nxt  = '0;
                    second_nxt = '0;
                    result_nxt = '0;
                    cnt_nxt    = '0;
                end else if (is_next) begin
                    nxt_state = REQUEST;
                end else if (is_digit && !cnt_full) begin
                    second_nxt = {second_num[W-5:0], key_code};
                    cnt_nxt    = cnt_q + 1'b1;
                end
            end
            // Keys and CLEAR are deliberately dropped until the adder answers.
            REQUEST: begin
                if (op_ready) nxt_state = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_valid) begin
                    result_nxt = res_data;
                    nxt_state  = SHOW;
                end
            end
            SHOW: begin
                if (is_clear) begin
                    nxt_state  = ENTER_A;
                    first_nxt  = '0;
                    second_nxt = '0;
                    result_nxt = '0;
                    cnt_nxt    = '0;
                end else if (is_digit) begin
                    nxt_state  = ENTER_A;
                    first_nxt  = {{(W-4){1'b0}}, key_code};
                    second_nxt = '0;
                    cnt_nxt    = CW'(1);
                end
            end
            default: nxt_state = ENTER_A;
        endcase

        // Display is registered, so it is derived from the upcoming state.
        case (nxt_state)
            ENTER_A:                    disp_nxt = {4'h0, first_nxt};
            ENTER_B, REQUEST, WAIT_RES: disp_nxt = {4'h0, second_nxt};
            SHOW:                       disp_nxt = result_nxt;
            default:                    disp_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= ENTER_A;
            first_num  <= '0;
            second_num <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            op_valid   <= 1'b0;
            disp_value <= '0;
        end else begin
            cur_state  <= nxt_state;
            first_num  <= first_nxt;
            second_num <= second_nxt;
            result_q   <= result_nxt;
            cnt_q      <= cnt_nxt;
            op_valid   <= (nxt_state == REQUEST);
            disp_value <= disp_nxt;
        end
    end

endmodule

// File: tb/tb_module_calc_ctrl.sv
// Bench for module_calc_ctrl: directed key sequences, with a scoreboard that
// checks operand pairs at each adder handshake and the display on SHOW entry.
module tb_module_calc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [11:0] first_num, second_num;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic [15:0] res_data = 16'h0;
    logic [15:0] disp_value;
    logic [2:0]  state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [23:0] pair_q[$];
    logic [15:0] disp_q[$];
    logic [2:0]  prev_state = 3'd0;

    module_calc_ctrl #(.DIGITS(3)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .first_num(first_num), .second_num(second_num), .op_valid(op_valid),
        .op_ready(op_ready), .res_valid(res_valid), .res_data(res_data),
        .disp_value(disp_value), .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk); #1;
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic applyResult(input logic [15:0] data);
        @(negedge clk); #1;
        res_valid = 1'b1;
        res_data  = data;
        @(negedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic checkAll(input string tag, input logic [2:0] st, input logic [11:0] a,
                            input logic [11:0] b, input logic ov, input logic [15:0] disp);
        checkOutput({tag, " state"}, {21'd0, state}, {21'd0, st});
        checkOutput({tag, " first_num"}, {12'd0, first_num}, {12'd0, a});
        checkOutput({tag, " second_num"}, {12'd0, second_num}, {12'd0, b});
        checkOutput({tag, " op_valid"}, {23'd0, op_valid}, {23'd0, ov});
        checkOutput({tag, " disp_value"}, {8'd0, disp_value}, {8'd0, disp});
    endtask

    // Monitor samples late in the low phase, after stimulus settles and before the edge.
    always @(negedge clk) begin
        #3;
        if (op_valid && op_ready) begin
            if (pair_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL handshake: unexpected pair %h/%h", first_num, second_num);
            end else begin
                checkOutput("handshake operands", {first_num, second_num}, pair_q.pop_front());
            end
        end
        if (state == 3'd4 && prev_state != 3'd4) begin
            if (disp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL show: unexpected SHOW entry, disp %h", disp_value);
            end else begin
                checkOutput("show disp_value", {8'd0, disp_value}, {8'd0, disp_q.pop_front()});
            end
        end
        prev_state = state;
    end

    initial begin
        // Reset state
        #12;
        checkAll("reset", 3'd0, 12'h000, 12'h000, 1'b0, 16'h0000);
        @(negedge clk); #1;
        rst = 1'b1;

        // Basic add: 123 + 456
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'h3);
        checkAll("entry A", 3'd0, 12'h123, 12'h000, 1'b0, 16'h0123);
        applyStimulus(4'hA);
        checkAll("to B", 3'd1, 12'h123, 12'h000, 1'b0, 16'h0000);
        applyStimulus(4'h4);
        applyStimulus(4'h5);
        applyStimulus(4'h6);
        pair_q.push_back({12'h123, 12'h456});
        applyStimulus(4'hA);
        checkAll("request", 3'd2, 12'h123, 12'h456, 1'b1, 16'h0456);
        op_ready = 1'b1;
        @(negedge clk); #1;
        op_ready = 1'b0;
        checkAll("wait res", 3'd3, 12'h123, 12'h456, 1'b0, 16'h0456);
        @(negedge clk);
        @(negedge clk);
        disp_q.push_back(16'h0579);
        applyResult(16'h0579);
        checkAll("show", 3'd4, 12'h123, 12'h456, 1'b0, 16'h0579);

        // NEXT ignored in SHOW, then digit restarts entry
        applyStimulus(4'hA);
        checkOutput("show next state", {21'd0, state}, 24'd4);
        applyStimulus(4'h7);
        checkAll("show digit", 3'd0, 12'h007, 12'h000, 1'b0, 16'h0007);

        // CLEAR, then overflow digit, then empty second operand
        applyStimulus(4'hB);
        checkAll("clear", 3'd0, 12'h000, 12'h000, 1'b0, 16'h0000);
        applyStimulus(4'h9);
        applyStimulus(4'h8);
        applyStimulus(4'h7);
        applyStimulus(4'h6);
        checkAll("overflow", 3'd0, 12'h987, 12'h000, 1'b0, 16'h0987);
        applyStimulus(4'hA);
        pair_q.push_back({12'h987, 12'h000});
        applyStimulus(4'hA);
        checkAll("empty B", 3'd2, 12'h987, 12'h000, 1'b1, 16'h0000);

        // Stalled REQUEST ignores keys and CLEAR
        applyStimulus(4'h5);
        applyStimulus(4'hB);
        @(negedge clk); #1;
        checkAll("stall", 3'd2, 12'h987, 12'h000, 1'b1, 16'h0000);
        op_ready = 1'b1;
        @(negedge clk); #1;
        op_ready = 1'b0;
        checkAll("stall release", 3'd3, 12'h987, 12'h000, 1'b0, 16'h0000);

        // Result and key in the same WAIT_RES cycle: key dropped
        @(negedge clk); #1;
        disp_q.push_back(16'h0987);
        res_valid = 1'b1;
        res_data  = 16'h0987;
        key_valid = 1'b1;
        key_code  = 4'h3;
        @(negedge clk); #1;
        res_valid = 1'b0;
        key_valid = 1'b0;
        checkAll("res+key", 3'd4, 12'h987, 12'h000, 1'b0, 16'h0987);
        applyStimulus(4'hB);
        checkAll("show clear", 3'd0, 12'h000, 12'h000, 1'b0, 16'h0000);

        // Stray result and ignored codes in ENTER_B
        applyStimulus(4'h1);
        applyStimulus(4'hA);
        applyStimulus(4'h2);
        applyResult(16'h1111);
        checkAll("stray res", 3'd1, 12'h001, 12'h002, 1'b0, 16'h0002);
        for (int c = 12; c < 16; c++) applyStimulus(4'(c));
        checkAll("ignored codes", 3'd1, 12'h001, 12'h002, 1'b0, 16'h0002);

        // Asynchronous reset mid-REQUEST
        applyStimulus(4'hA);
        checkOutput("pre-reset op_valid", {23'd0, op_valid}, 24'd1);
        #2;
        rst = 1'b0;
        #1;
        checkAll("async reset", 3'd0, 12'h000, 12'h000, 1'b0, 16'h0000);
        @(negedge clk); #1;
        rst = 1'b1;

        @(negedge clk);
        @(negedge clk);
        checkOutput("pair queue empty", 24'(pair_q.size()), 24'd0);
        checkOutput("disp queue empty", 24'(disp_q.size()), 24'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/module_calc_ctrl.md
# module_calc_ctrl

Sequencing controller for the keypad calculator datapath. It takes decoded, debounced key strobes from the keypad front end and assembles two BCD operands of `DIGITS` digits each. It then hands the operand pair to the BCD adder over a valid/ready handshake, captures the result, and drives the value shown on the display. It sits between the keypad decoder and the adder/display blocks and owns all entry sequencing: first operand, second operand, compute and show.

## Interface

Parameters:
- `DIGITS`, default 3: BCD digits per operand.
- `W`, default `4*DIGITS`: operand width in bits; derived, do not override.

Ports:
- `clk`: input, 1 bit. System clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Reset, asynchronous, active-low.
- `key_valid`: input, 1 bit. One-cycle strobe; `key_code` is valid this cycle.
- `key_code`: input, 4 bits.
  - 0x0–0x9: digit.
  - 0xA: NEXT.
  - 0xB: CLEAR.
  - 0xC–0xF: ignored.
- `first_num`: output, W bits. First operand, BCD, least significant digit in [3:0].
- `second_num`: output, W bits. Second operand, BCD.
- `op_valid`: output, 1 bit. Operand pair is presented to the adder.
- `op_ready`: input, 1 bit. Adder accepts the pair when `op_valid && op_ready`.
- `res_valid`: input, 1 bit. One-cycle strobe; `res_data` is valid.
- `res_data`: input, W+4 bits. BCD sum, DIGITS+1 digits.
- `disp_value`: output, W+4 bits. Value for the 7-segment driver, BCD.
- `state`: output, 3 bits. FSM state encoding, for debug and the bench.

## Operation

States and encodings:
- ENTER_A = 0
- ENTER_B = 1
- REQUEST = 2
- WAIT_RES = 3
- SHOW = 4

Reset (`rst` = 0, asynchronous):
- State is ENTER_A.
- `first_num`, `second_num`, the result register and the digit counter are 0.
- `op_valid` is 0.
- `disp_value` is 0.

Digit entry (ENTER_A targets `first_num`, ENTER_B targets `second_num`):
- Shift left one digit: operand <= {operand[W-5:0], key_code}. The counter increments.
- Once the counter equals DIGITS, further digits are ignored; the operand holds.
- Leading zeros are stored as entered.

NEXT (0xA):
- ENTER_A to ENTER_B. The counter clears and `second_num` clears.
- ENTER_B to REQUEST. `op_valid` rises.
- NEXT with zero digits entered is legal; the operand is 0.
- In SHOW, NEXT is ignored.

REQUEST:
- `op_valid` = 1, and `first_num`/`second_num` are held stable.
- On `op_ready` = 1, go to WAIT_RES. `op_valid` is 0 from the next cycle.

WAIT_RES:
- On `res_valid`, the result register <= `res_data` and the state goes to SHOW.

SHOW:
- A digit key clears both operands, loads the digit into `first_num` with the counter at 1, and goes to ENTER_A.

CLEAR (0xB):
- In ENTER_A, ENTER_B or SHOW: both operands, the counter and the result register clear, and the state goes to ENTER_A.
- In REQUEST or WAIT_RES, CLEAR is ignored. An in-flight handshake is never abandoned.

Keys are ignored in REQUEST and WAIT_RES. Codes 0xC–0xF are ignored in every state.

`disp_value` by state:
- ENTER_A: {4'h0, `first_num`}
- ENTER_B, REQUEST and WAIT_RES: {4'h0, `second_num`}
- SHOW: the result register

No arithmetic is done in this block; operands are passed to the adder unchanged.

## Timing

- All outputs are registered.
- A key accepted at edge N is visible on operands, `state` and `disp_value` after edge N.
- `op_valid` is asserted the cycle after NEXT is accepted in ENTER_B. It stays high until the edge at which `op_ready` = 1 is sampled, then deasserts.
  - Minimum REQUEST dwell is 1 cycle, when `op_ready` is already high.
- `op_ready` is a don't-care while `op_valid` = 0.
- `res_valid` outside WAIT_RES is ignored.
  - This includes `res_valid` in the same cycle as the REQUEST→WAIT_RES transition. The adder guarantees at least one cycle of latency.
- `res_valid` and `key_valid` in the same WAIT_RES cycle: the result is captured and the key is dropped.
- `key_valid` high on consecutive cycles counts as separate keys. The front end guarantees one pulse per press.
- Asserting `rst` mid-handshake drops `op_valid` immediately, asynchronously.

## Test plan

1. Reset, then keys 1,2,3,NEXT,4,5,6,NEXT, then `op_ready` = 1 and, 3 cycles later, `res_valid` with `res_data` = 16'h0579.
   - Expected: `first_num` = 12'h123 and `second_num` = 12'h456 while `op_valid` is high; `op_valid` is high for exactly 1 cycle.
   - SHOW with `disp_value` = 16'h0579.
2. Keys 9,8,7,6 in ENTER_A.
   - Expected: `first_num` = 12'h987, with the fourth digit ignored.
   - Then NEXT, NEXT: REQUEST with `second_num` = 0.
3. Hold `op_ready` = 0 for 5 cycles in REQUEST while pulsing keys 5 and CLEAR.
   - Expected: `op_valid` stays 1, operands are unchanged and the state stays 2.
   - `op_ready` = 1 gives WAIT_RES.
4. In SHOW, press 7.
   - Expected: state 0, `first_num` = 12'h007, `second_num` = 0.
   - Alternatively press CLEAR: everything is 0 and `disp_value` = 0.
5. Assert `rst` low asynchronously mid-REQUEST, between clock edges.
   - Expected: `op_valid`, operands and `disp_value` are 0 immediately, and the state is 0.
6. Pulse `res_valid` in ENTER_B, then keys 0xC–0xF.
   - Expected: no state change and no operand change.
